// File: rtl/coprocessor0_interrupt_timer.sv
`timescale 1ns/1ps
// CP0 register unit: Status/Cause/EPC/BadVAddr plus a prescaled Count/Compare timer.
// Exceptions latch at writeback; hardware lines and TI combine into one interrupt request.
module coprocessor0_interrupt_timer #(
   parameter int HW_INT_COUNT  = 6,
   parameter int COUNT_DIVIDER = 2
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    write_enabled,
   input  logic [4:0]              address_register,
   input  logic [2:0]              address_select,
   input  logic [31:0]             write_data,
   output logic [31:0]             read_data,
   input  logic                    exception_valid,
   input  logic [4:0]              exception_code,
   input  logic [31:0]             exception_address,
   input  logic                    in_delay_slot,
   input  logic                    bad_address_valid,
   input  logic [31:0]             bad_address,
   input  logic                    eret_flush,
   input  logic [HW_INT_COUNT-1:0] hardware_interrupt,
   output logic                    interrupt_pending,
   output logic                    exception_level,
   output logic [31:0]             epc
);

   localparam logic [3:0] PRESCALE_LAST = 4'(COUNT_DIVIDER - 1);

   logic [7:0]              status_im;
   logic                    status_exl;
   logic                    status_ie;
   logic                    cause_bd;
   logic                    cause_ti;
   logic [1:0]              cause_ip_sw;
   logic [4:0]              cause_exc;
   logic [HW_INT_COUNT-1:0] hw_q;
   logic [31:0]             epc_q;
   logic [31:0]             bad_vaddr;
   logic [31:0]             count;
   logic [31:0]             compare;
   logic [3:0]              prescale;

   logic [5:0]  hw_ip;
   logic [7:0]  cause_ip;
   logic        mtc0;
   logic        wr_count;
   logic        wr_compare;
   logic        wr_status;
   logic        wr_cause;
   logic        wr_epc;
   logic        tick;
   logic        count_step;
   logic        ti_hit;

   // Lines beyond HW_INT_COUNT read as zero in IP
   always_comb begin
      hw_ip = '0;
      hw_ip[HW_INT_COUNT-1:0] = hw_q;
   end

   assign cause_ip   = {hw_ip[5] | cause_ti, hw_ip[4:0], cause_ip_sw};
   assign mtc0       = write_enabled & ~exception_valid & (address_select == 3'd0);
   assign wr_count   = mtc0 & (address_register == 5'd9);
   assign wr_compare = mtc0 & (address_register == 5'd11);
   assign wr_status  = mtc0 & (address_register == 5'd12);
   assign wr_cause   = mtc0 & (address_register == 5'd13);
   assign wr_epc     = mtc0 & (address_register == 5'd14);
   assign tick       = (prescale == PRESCALE_LAST);
   assign count_step = tick & ~wr_count;
   assign ti_hit     = count_step & ((count + 32'd1) == compare);

   always_ff @(posedge clock) begin
      if (reset) begin
         status_im   <= '0;
         status_exl  <= 1'b0;
         status_ie   <= 1'b0;
         cause_bd    <= 1'b0;
         cause_ti    <= 1'b0;
         cause_ip_sw <= '0;
         cause_exc   <= '0;
         hw_q        <= '0;
         epc_q       <= '0;
         bad_vaddr   <= '0;
         count       <= '0;
         compare     <= '0;
         prescale    <= '0;
      end else begin
         hw_q <= hardware_interrupt;
         if (exception_valid)
            status_exl <= 1'b1;
         else if (eret_flush)
            status_exl <= 1'b0;
         else if (wr_status)
            status_exl <= write_data[1];
         if (wr_status) begin
            status_im <= write_data[15:8];
            status_ie <= write_data[0];
         end
         if (wr_cause)
            cause_ip_sw <= write_data[9:8];
         // Nested exceptions keep the original return address
         if (exception_valid) begin
            cause_exc <= exception_code;
            if (!status_exl) begin
               epc_q    <= in_delay_slot ? exception_address - 32'd4
                                         : exception_address;
               cause_bd <= in_delay_slot;
            end
            if (bad_address_valid)
               bad_vaddr <= bad_address;
         end else if (wr_epc) begin
            epc_q <= write_data;
         end
         if (wr_compare)
            compare <= write_data;
         if (wr_compare)
            cause_ti <= 1'b0;
         else if (ti_hit)
            cause_ti <= 1'b1;
         if (wr_count) begin
            count    <= write_data;
            prescale <= '0;
         end else if (tick) begin
            count    <= count + 32'd1;
            prescale <= '0;
         end else begin
            prescale <= prescale + 4'd1;
         end
      end
   end

   assign interrupt_pending = status_ie & ~status_exl & |(status_im & cause_ip);
   assign exception_level   = status_exl;
   assign epc               = epc_q;

   always_comb begin
      read_data = '0;
      if (address_select == 3'd0) begin
         case (address_register)
            5'd8:    read_data = bad_vaddr;
            5'd9:    read_data = count;
            5'd11:   read_data = compare;
            5'd12:   read_data = {9'd0, 1'b1, 6'd0, status_im,
                                  6'd0, status_exl, status_ie};
            5'd13:   read_data = {cause_bd, cause_ti, 14'd0, cause_ip,
                                  1'b0, cause_exc, 2'b00};
            5'd14:   read_data = epc_q;
            default: read_data = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_coprocessor0_interrupt_timer.sv
`timescale 1ns/1ps
// Bench for coprocessor0_interrupt_timer: directed plan steps, then random
// traffic checked against a cycle-level reference model of the register rules.
module tb_coprocessor0_interrupt_timer;

   localparam int HW  = 6;
   localparam int DIV = 2;

   logic          clock = 1'b0;
   logic          reset;
   logic          write_enabled;
   logic [4:0]    address_register;
   logic [2:0]    address_select;
   logic [31:0]   write_data;
   logic [31:0]   read_data;
   logic          exception_valid;
   logic [4:0]    exception_code;
   logic [31:0]   exception_address;
   logic          in_delay_slot;
   logic          bad_address_valid;
   logic [31:0]   bad_address;
   logic          eret_flush;
   logic [HW-1:0] hardware_interrupt;
   logic          interrupt_pending;
   logic          exception_level;
   logic [31:0]   epc;

   int checks   = 0;
   int failures = 0;

   logic [7:0]  m_im;
   logic        m_exl, m_ie, m_bd, m_ti;
   logic [1:0]  m_sw;
   logic [4:0]  m_exc;
   logic [5:0]  m_hw;
   logic [31:0] m_epc, m_bad, m_count, m_compare;
   int          m_phase;

   always #50 clock = ~clock;

   coprocessor0_interrupt_timer #(
      .HW_INT_COUNT (HW),
      .COUNT_DIVIDER(DIV)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .write_enabled     (write_enabled),
      .address_register  (address_register),
      .address_select    (address_select),
      .write_data        (write_data),
      .read_data         (read_data),
      .exception_valid   (exception_valid),
      .exception_code    (exception_code),
      .exception_address (exception_address),
      .in_delay_slot     (in_delay_slot),
      .bad_address_valid (bad_address_valid),
      .bad_address       (bad_address),
      .eret_flush        (eret_flush),
      .hardware_interrupt(hardware_interrupt),
      .interrupt_pending (interrupt_pending),
      .exception_level   (exception_level),
      .epc               (epc)
   );

   function automatic logic [7:0] m_ip();
      return {m_hw[5] | m_ti, m_hw[4:0], m_sw};
   endfunction

   function automatic logic m_pend();
      return m_ie & ~m_exl & (|(m_im & m_ip()));
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a,
                                          input logic [2:0] s);
      if (s != 3'd0) return 32'd0;
      case (a)
         5'd8:    return m_bad;
         5'd9:    return m_count;
         5'd11:   return m_compare;
         5'd12:   return {9'd0, 1'b1, 6'd0, m_im, 6'd0, m_exl, m_ie};
         5'd13:   return {m_bd, m_ti, 14'd0, m_ip(), 1'b0, m_exc, 2'b00};
         5'd14:   return m_epc;
         default: return 32'd0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      write_enabled     = 1'b0;
      address_register  = 5'd0;
      address_select    = 3'd0;
      write_data        = 32'd0;
      exception_valid   = 1'b0;
      exception_code    = 5'd0;
      exception_address = 32'd0;
      in_delay_slot     = 1'b0;
      bad_address_valid = 1'b0;
      bad_address       = 32'd0;
      eret_flush        = 1'b0;
   endtask

   // One clock edge: model consumes the same inputs, then outputs are compared
   task automatic cycle();
      logic        we, wc, wcmp, ws, wca, wep, tk;
      logic [7:0]  n_im;
      logic        n_exl, n_ie, n_bd, n_ti;
      logic [1:0]  n_sw;
      logic [4:0]  n_exc;
      logic [5:0]  n_hw;
      logic [31:0] n_epc, n_bad, n_count, n_compare;
      int          n_phase;
      we   = write_enabled && !exception_valid && address_select == 3'd0;
      wc   = we && address_register == 5'd9;
      wcmp = we && address_register == 5'd11;
      ws   = we && address_register == 5'd12;
      wca  = we && address_register == 5'd13;
      wep  = we && address_register == 5'd14;
      tk   = (m_phase == DIV - 1);
      if (reset) begin
         n_im = 0; n_exl = 0; n_ie = 0; n_bd = 0; n_ti = 0; n_sw = 0;
         n_exc = 0; n_hw = 0; n_epc = 0; n_bad = 0; n_count = 0;
         n_compare = 0; n_phase = 0;
      end else begin
         n_hw  = hardware_interrupt;
         n_exl = exception_valid ? 1'b1 : eret_flush ? 1'b0 :
                 ws ? write_data[1] : m_exl;
         n_im  = ws ? write_data[15:8] : m_im;
         n_ie  = ws ? write_data[0] : m_ie;
         n_sw  = wca ? write_data[9:8] : m_sw;
         n_epc = m_epc;
         n_bd  = m_bd;
         if (exception_valid && !m_exl) begin
            n_epc = in_delay_slot ? exception_address - 32'd4
                                  : exception_address;
            n_bd  = in_delay_slot;
         end else if (wep) begin
            n_epc = write_data;
         end
         n_exc     = exception_valid ? exception_code : m_exc;
         n_bad     = (exception_valid && bad_address_valid) ? bad_address : m_bad;
         n_compare = wcmp ? write_data : m_compare;
         n_ti      = m_ti;
         if (wcmp) n_ti = 1'b0;
         else if (!wc && tk && (m_count + 32'd1) == m_compare) n_ti = 1'b1;
         if (wc) begin
            n_count = write_data; n_phase = 0;
         end else if (tk) begin
            n_count = m_count + 32'd1; n_phase = 0;
         end else begin
            n_count = m_count; n_phase = m_phase + 1;
         end
      end
      @(posedge clock);
      #1;
      m_im = n_im; m_exl = n_exl; m_ie = n_ie; m_bd = n_bd; m_ti = n_ti;
      m_sw = n_sw; m_exc = n_exc; m_hw = n_hw; m_epc = n_epc; m_bad = n_bad;
      m_count = n_count; m_compare = n_compare; m_phase = n_phase;
      chk("pending", 32'(interrupt_pending), 32'(m_pend()));
      chk("exl_out", 32'(exception_level), 32'(m_exl));
      chk("epc_out", epc, m_epc);
   endtask

   task automatic rd(input string tag, input logic [4:0] a,
                     input logic [31:0] exp);
      address_register = a;
      address_select   = 3'd0;
      #1;
      chk(tag, read_data, exp);
      chk({tag, "_model"}, read_data, m_read(a, 3'd0));
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      idle();
      write_enabled    = 1'b1;
      address_register = a;
      write_data       = d;
      cycle();
      idle();
   endtask

   logic [4:0] addrs [8] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd31};

   initial begin
      logic [4:0] ra;
      logic [2:0] rs;
      idle();
      hardware_interrupt = '0;
      reset = 1'b1;
      m_phase = 0;
      cycle();
      cycle();
      reset = 1'b0;

      rd("rst_status", 5'd12, 32'h0040_0000);
      rd("rst_cause", 5'd13, 32'h0);
      rd("rst_epc", 5'd14, 32'h0);
      rd("rst_count", 5'd9, 32'h0);
      rd("rst_badva", 5'd8, 32'h0);
      chk("rst_pending", 32'(interrupt_pending), 32'h0);

      idle();
      exception_valid = 1'b1; exception_code = 5'd4;
      exception_address = 32'hBFC0_0100; in_delay_slot = 1'b1;
      bad_address_valid = 1'b1; bad_address = 32'h1234;
      cycle();
      idle();
      rd("exc_epc", 5'd14, 32'hBFC0_00FC);
      rd("exc_cause", 5'd13, 32'h8000_0010);
      rd("exc_badva", 5'd8, 32'h1234);
      rd("exc_status", 5'd12, 32'h0040_0002);
      chk("exc_exl", 32'(exception_level), 32'h1);

      idle();
      exception_valid = 1'b1; exception_code = 5'd5;
      exception_address = 32'h8000_0000;
      cycle();
      idle();
      rd("nest_epc", 5'd14, 32'hBFC0_00FC);
      rd("nest_cause", 5'd13, 32'h8000_0014);
      eret_flush = 1'b1;
      cycle();
      idle();
      chk("eret_exl", 32'(exception_level), 32'h0);

      mtc0(5'd11, 32'h0000_0001);
      mtc0(5'd9, 32'hFFFF_FFFE);
      rd("cnt_load", 5'd9, 32'hFFFF_FFFE);
      idle(); cycle(); cycle();
      rd("cnt_ffff", 5'd9, 32'hFFFF_FFFF);
      idle(); cycle(); cycle();
      rd("cnt_wrap", 5'd9, 32'h0);
      rd("ti_before", 5'd13, 32'h8000_0014);
      idle(); cycle(); cycle();
      rd("cnt_one", 5'd9, 32'h1);
      rd("ti_set", 5'd13, 32'hC000_8014);
      mtc0(5'd11, 32'h5);
      rd("ti_clr", 5'd13, 32'h8000_0014);

      mtc0(5'd12, 32'h0000_0401);
      chk("irq_idle", 32'(interrupt_pending), 32'h0);
      hardware_interrupt = 6'b000001;
      cycle();
      chk("irq_rise", 32'(interrupt_pending), 32'h1);
      hardware_interrupt = '0;
      cycle();
      chk("irq_fall", 32'(interrupt_pending), 32'h0);
      hardware_interrupt = 6'b000001;
      cycle();
      mtc0(5'd12, 32'h0000_0403);
      chk("irq_exl_mask", 32'(interrupt_pending), 32'h0);
      chk("irq_exl_lvl", 32'(exception_level), 32'h1);
      hardware_interrupt = '0;
      mtc0(5'd12, 32'h0);

      idle();
      exception_valid = 1'b1; exception_code = 5'd0;
      exception_address = 32'h0000_1000;
      write_enabled = 1'b1; address_register = 5'd14;
      write_data = 32'hDEAD_0000;
      cycle();
      idle();
      rd("exc_vs_mtc0", 5'd14, 32'h0000_1000);
      eret_flush = 1'b1;
      cycle();
      idle();

      mtc0(5'd11, 32'h0000_0101);
      mtc0(5'd9, 32'h0000_0100);
      idle(); cycle();
      mtc0(5'd11, 32'h0000_0101);
      rd("ti_clr_wins", 5'd13, 32'h0);
      rd("ti_clr_cnt", 5'd9, 32'h0000_0101);

      mtc0(5'd13, 32'hFFFF_FFFF);
      rd("cause_sw", 5'd13, 32'h0000_0300);
      mtc0(5'd12, 32'h0000_0201);
      chk("sw_irq", 32'(interrupt_pending), 32'h1);

      for (int i = 0; i < 400; i++) begin
         idle();
         reset = ($urandom_range(0, 63) == 0);
         hardware_interrupt = 6'($urandom);
         if ($urandom_range(0, 2) == 0) begin
            write_enabled    = 1'b1;
            address_register = addrs[$urandom_range(0, 7)];
            address_select   = ($urandom_range(0, 7) == 0) ? 3'd1 : 3'd0;
            write_data       = $urandom;
            if (address_register == 5'd9 && $urandom_range(0, 1) == 0)
               write_data = m_compare - 32'd1;
         end
         if ($urandom_range(0, 7) == 0) begin
            exception_valid   = 1'b1;
            exception_code    = 5'($urandom);
            exception_address = $urandom;
            in_delay_slot     = 1'($urandom);
            bad_address_valid = 1'($urandom);
            bad_address       = $urandom;
         end
         eret_flush = ($urandom_range(0, 7) == 0);
         cycle();
         reset = 1'b0;
         ra = addrs[$urandom_range(0, 7)];
         rs = ($urandom_range(0, 7) == 0) ? 3'd2 : 3'd0;
         address_register = ra;
         address_select   = rs;
         #1;
         chk("rand_read", read_data, m_read(ra, rs));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/coprocessor0_interrupt_timer.md
# coprocessor0_interrupt_timer

Parametrised CP0 register unit for the MIPS core. It holds Status, Cause, EPC, BadVAddr, Count and Compare, and latches exception state at writeback. It also samples a configurable number of hardware interrupt lines, runs a prescaled Count/Compare timer, and raises a single interrupt request to the pipeline. It sits beside writeback: writes and exceptions come from WB, EPC goes to IF, and read data goes to the MFC0 path.

## Interface
- HW_INT_COUNT, 6: number of hardware interrupt inputs, range 1..6. Line i maps to Cause.IP[2+i]. IP bits above 2+HW_INT_COUNT-1 read 0, except IP7 when the timer is set.
- COUNT_DIVIDER, 2: Count increments once every COUNT_DIVIDER cycles, range 1..16.
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- write_enabled  in  1  MTC0 commit from WB.
- address_register  in  5  CP0 register number for read and write.
- address_select  in  3  CP0 select field. Only select 0 is mapped.
- write_data  in  32  MTC0 data.
- read_data  out  32  combinational MFC0 data; unmapped addresses return 0.
- exception_valid  in  1  exception commits this cycle.
- exception_code  in  5  ExcCode for Cause.
- exception_address  in  32  PC of the faulting instruction.
- in_delay_slot  in  1  faulting instruction is in a delay slot.
- bad_address_valid  in  1  exception carries a bad virtual address.
- bad_address  in  32  faulting virtual address.
- eret_flush  in  1  ERET commits this cycle.
- hardware_interrupt  in  HW_INT_COUNT  level-sensitive interrupt lines.
- interrupt_pending  out  1  IE & !EXL & |(IM & IP).
- exception_level  out  1  Status.EXL.
- epc  out  32  EPC register, to IF.

## Operation
- Register map (reg, sel 0):
  - BadVAddr 8: read-only.
  - Count 9: read/write.
  - Compare 11: read/write.
  - Status 12: BEV bit22 is read-only and reads 1; IM[15:8], EXL bit1 and IE bit0 are read/write.
  - Cause 13: BD bit31, TI bit30, IP[15:8], ExcCode[6:2]. Only IP[1:0] is writable.
  - EPC 14: read/write.
  - All other bits read 0.
- When exception_valid=1, write_enabled is ignored that cycle.
- Status.EXL:
  - exception_valid sets it to 1.
  - Otherwise, eret_flush clears it to 0.
  - Otherwise, an MTC0 to Status writes it.
- EPC and Cause.BD update on exception_valid only when EXL=0 before the edge.
  - EPC = in_delay_slot ? exception_address-4 : exception_address, modulo 2^32.
  - BD = in_delay_slot.
- Cause.ExcCode updates on every exception_valid, regardless of EXL.
- BadVAddr updates on exception_valid & bad_address_valid.
- IP[2+i] is registered from hardware_interrupt[i] every cycle, with no stickiness.
- IP7 = (hardware line 5 if HW_INT_COUNT=6) | TI.
- Prescaler counts 0..COUNT_DIVIDER-1. A tick occurs when it equals COUNT_DIVIDER-1; on a tick the prescaler returns to 0 and Count increments.
  - Count wraps from 0xFFFFFFFF to 0.
  - With COUNT_DIVIDER=1, every cycle is a tick.
- MTC0 Count loads write_data, clears the prescaler and suppresses that cycle's tick.
- TI sets on a tick where Count+1 == Compare.
- MTC0 Compare loads Compare and clears TI. If a TI-setting tick occurs in the same cycle, the clear wins.
- Reset values:
  - Status: IM=0, EXL=0, IE=0.
  - Cause: all fields 0.
  - EPC, BadVAddr, Count, Compare and the prescaler: 0.
  - Resulting outputs: interrupt_pending=0, exception_level=0, epc=0.
- Reset mid-count discards the prescaler phase.

## Timing
- Every write, exception, ERET and interrupt sample takes effect at the next rising edge. It is visible on read_data and outputs in the following cycle.
- Read in the same cycle as a write to that register returns the old value.
- hardware_interrupt rises in cycle N: IP is set after edge N+1, so interrupt_pending is 1 in cycle N+1 if enabled.
- interrupt_pending, exception_level and epc are direct functions of registers, with no input-to-output combinational path.
- read_data is combinational from address_register and address_select.

## Test plan
- Reset, then read registers 12, 13, 14, 9 and 8 → 0x00400000, 0, 0, 0, 0. interrupt_pending=0.
- Exception with code 4, address 0xBFC00100, in_delay_slot=1, bad_address 0x1234, EXL=0 → EPC=0xBFC000FC, BD=1, ExcCode=4, BadVAddr=0x1234, EXL=1.
  - A second exception with address 0x80000000 leaves EPC unchanged and updates ExcCode.
  - ERET clears EXL.
- COUNT_DIVIDER=2: write Count=0xFFFFFFFE and Compare=0x00000001 → Count reads 0xFFFFFFFF, then 0, then 1 at 2-cycle steps. TI=1 after the tick to 1.
  - Write Compare=5 → TI=0 next cycle.
- Status IE=1 and IM=0x04 (IP2); assert hardware_interrupt[0] in cycle N → interrupt_pending=1 in cycle N+1.
  - Deassert the line → 0 one cycle later.
  - Setting EXL forces 0.
- Same cycle exception_valid and MTC0 EPC=0xDEAD0000 → EPC holds the exception value.
  - Same cycle Compare write and TI-setting tick → TI=0.
- MTC0 Cause=0xFFFFFFFF → only IP[1:0] set (read 0x00000300 with no other sources).
  - IE=1, IM[1]=1 → interrupt_pending=1.
